// File: rtl/teras_bridge_pkg.sv
// Shared constants for the teras result return path: data width, register
// offsets selected by adr[3:2], STATUS/CONTROL bit positions and a STATUS
// packing helper.
package teras_bridge_pkg;

    localparam int DATA_W = 32;

    // Register select field, taken from wbs_adr_i[3:2]
    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CONTROL = 2'd2,
        REG_RSVD    = 2'd3
    } reg_sel_e;

    // STATUS register layout
    localparam int STAT_COUNT_W = 9;
    localparam int STAT_EMPTY   = 16;
    localparam int STAT_FULL    = 17;
    localparam int STAT_OVF     = 18;
    localparam int STAT_UNF     = 19;
    localparam int STAT_IRQ     = 20;

    // CONTROL register layout
    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_FLAGS = 1;

    // Assemble the STATUS word; unused bits read as zero
    function automatic logic [DATA_W-1:0] pack_status(
        input logic [STAT_COUNT_W-1:0] count,
        input logic                    empty,
        input logic                    full,
        input logic                    ovf,
        input logic                    unf,
        input logic                    irq
    );
        logic [DATA_W-1:0] s;
        s                   = {DATA_W{1'b0}};
        s[STAT_COUNT_W-1:0] = count;
        s[STAT_EMPTY]       = empty;
        s[STAT_FULL]        = full;
        s[STAT_OVF]         = ovf;
        s[STAT_UNF]         = unf;
        s[STAT_IRQ]         = irq;
        return s;
    endfunction

endpackage

// File: rtl/teras_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. Push is ignored when full, pop is
// ignored when empty, and flush has priority over both (it resets the
// pointers, so a word pushed on the flush edge is discarded).
module teras_sync_fifo
    import teras_bridge_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign do_push_s = push_i && !full_s && !flush_i;
    assign do_pop_s  = pop_i && !empty_s && !flush_i;

    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values: flush returns both to zero, otherwise advance on accepted ops
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/teras_result_reader.sv
// Result return path: buffers the accelerator's rts/rtr word stream in a FIFO
// and exposes it to the management core as a Wishbone slave (DATA pop,
// STATUS, CONTROL), with sticky stall/underflow flags and a threshold irq.
module teras_result_reader
    import teras_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0100,
    parameter int          DEPTH         = 16,
    parameter int          IRQ_THRESHOLD = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    input  logic              rts_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              rtr_o,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] IRQ_TH = CW'(IRQ_THRESHOLD);

    // FIFO interface
    logic [DATA_W-1:0] fifo_rdata_s;
    logic [CW-1:0]     fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              flush_s;

    // Bus decode
    logic              hit_s;
    logic              rd_hit_s;
    logic              wr_hit_s;
    reg_sel_e          sel_s;
    logic              clr_flags_s;
    logic [DATA_W-1:0] status_s;

    // Registers
    logic              ack_q;
    logic              ack_d;
    logic [DATA_W-1:0] dat_q;
    logic [DATA_W-1:0] dat_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;
    logic              irq_q;
    logic              irq_d;

    // Byte selects, low address bits and most write-data bits have no function
    logic              unused_s;
    assign unused_s = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[DATA_W-1:2]};

    // ack_q gates the hit so a held request is acked every other cycle
    assign hit_s    = wbs_cyc_i && wbs_stb_i &&
                      (wbs_adr_i[31:4] == BASE_ADDR[31:4]) && !ack_q;
    assign rd_hit_s = hit_s && !wbs_we_i;
    assign wr_hit_s = hit_s && wbs_we_i;
    assign sel_s    = reg_sel_e'(wbs_adr_i[3:2]);

    // rtr depends only on registered FIFO state, so a same-edge pop cannot open it
    assign rtr_o   = !fifo_full_s;
    assign push_s  = rts_i && rtr_o;
    assign pop_s   = rd_hit_s && (sel_s == REG_DATA);
    assign flush_s = wr_hit_s && (sel_s == REG_CONTROL) && wbs_dat_i[CTRL_FLUSH];
    assign clr_flags_s = wr_hit_s && (sel_s == REG_CONTROL) && wbs_dat_i[CTRL_CLR_FLAGS];

    assign status_s = pack_status(STAT_COUNT_W'(fifo_count_s), fifo_empty_s,
                                  fifo_full_s, ovf_q, unf_q, irq_q);

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

    teras_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .wdata_i (data_i),
        .rdata_o (fifo_rdata_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Bus response: ack follows a hit by one cycle, read data is zero outside the ack
    always_comb begin
        ack_d = hit_s;
        dat_d = {DATA_W{1'b0}};
        if (rd_hit_s) begin
            case (sel_s)
                REG_DATA: begin
                    if (fifo_empty_s) begin
                        dat_d = {DATA_W{1'b0}};
                    end else begin
                        dat_d = fifo_rdata_s;
                    end
                end
                REG_STATUS:  dat_d = status_s;
                REG_CONTROL: dat_d = {DATA_W{1'b0}};
                default:     dat_d = {DATA_W{1'b0}};
            endcase
        end else begin
            dat_d = {DATA_W{1'b0}};
        end
    end

    // Sticky flags: a set on the same edge as a clear takes priority
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (rts_i && fifo_full_s) begin
            ovf_d = 1'b1;
        end else if (clr_flags_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (pop_s && fifo_empty_s) begin
            unf_d = 1'b1;
        end else if (clr_flags_s) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Threshold interrupt tracks the registered count with one cycle of lag
    always_comb begin
        irq_d = (fifo_count_s >= IRQ_TH);
    end

    // Output and flag registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= {DATA_W{1'b0}};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            irq_q <= irq_d;
        end
    end

endmodule

// File: tb/tb_teras_result_reader.sv
// Directed bench for teras_result_reader: a reference FIFO model predicts
// every read, expected words go into a scoreboard queue when a request is
// issued and are compared when the ack arrives.
module tb_teras_result_reader;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam int          DEPTH = 16;
    localparam int          THR   = 8;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        rts_i;
    logic [31:0] data_i;
    logic        rtr_o;
    logic        irq;

    int          checks;
    int          failures;
    logic [31:0] mq[$];
    logic [31:0] sb_q[$];
    logic        ovf_m;
    logic        unf_m;
    logic        irq_at_ack;

    teras_result_reader #(
        .BASE_ADDR     (BASE),
        .DEPTH         (DEPTH),
        .IRQ_THRESHOLD (THR)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .rts_i     (rts_i),
        .data_i    (data_i),
        .rtr_o     (rtr_o),
        .irq       (irq)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = 32'h0;
        s[8:0]   = 9'(mq.size());
        s[16]    = (mq.size() == 0);
        s[17]    = (mq.size() == DEPTH);
        s[18]    = ovf_m;
        s[19]    = unf_m;
        s[20]    = (mq.size() >= THR);
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    // One accelerator word offered for a single edge; model follows the full rule
    task automatic push_word(input logic [31:0] d);
        @(negedge wb_clk_i);
        chk("rtr_before_push", {31'h0, rtr_o}, {31'h0, (mq.size() < DEPTH)});
        rts_i  = 1'b1;
        data_i = d;
        @(posedge wb_clk_i);
        if (mq.size() < DEPTH) mq.push_back(d);
        else ovf_m = 1'b1;
        #1;
        rts_i = 1'b0;
    endtask

    // Wishbone transfer; expected read word must already be on sb_q when an ack is expected
    task automatic bus(input string tag, input logic [31:0] adr, input logic we,
                       input logic [31:0] wd, input logic expect_ack);
        logic        got;
        logic [31:0] rd;
        logic [31:0] exp;
        got = 1'b0;
        rd  = 32'h0;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wd;
        for (int i = 0; i < 4; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o === 1'b1) begin
                got        = 1'b1;
                rd         = wbs_dat_o;
                irq_at_ack = irq;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        chk({tag, "_ack"}, {31'h0, got}, {31'h0, expect_ack});
        if (expect_ack) begin
            exp = sb_q.pop_front();
            if (got) begin
                chk({tag, "_data"}, rd, exp);
                @(posedge wb_clk_i);
                #1;
                chk({tag, "_ack_pulse"}, {31'h0, wbs_ack_o}, 32'h0);
                chk({tag, "_dat_idle"}, wbs_dat_o, 32'h0);
            end
        end
    endtask

    task automatic rd_data(input string tag);
        if (mq.size() > 0) begin
            sb_q.push_back(mq.pop_front());
        end else begin
            sb_q.push_back(32'h0);
            unf_m = 1'b1;
        end
        bus(tag, BASE + 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic rd_status(input string tag);
        idle(2);
        sb_q.push_back(exp_status());
        bus(tag, BASE + 32'h4, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic wr_ctrl(input string tag, input logic [31:0] v);
        if (v[0]) mq.delete();
        if (v[1]) begin
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end
        sb_q.push_back(32'h0);
        bus(tag, BASE + 32'h8, 1'b1, v, 1'b1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        ovf_m      = 1'b0;
        unf_m      = 1'b0;
        irq_at_ack = 1'b0;
        wb_rst_i   = 1'b1;
        wbs_stb_i  = 1'b0;
        wbs_cyc_i  = 1'b0;
        wbs_we_i   = 1'b0;
        wbs_sel_i  = 4'hF;
        wbs_dat_i  = 32'h0;
        wbs_adr_i  = 32'h0;
        rts_i      = 1'b0;
        data_i     = 32'h0;

        // Reset state
        idle(3);
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rtr", {31'h0, rtr_o}, 32'h1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        rd_status("rst_status");

        // Three words in, three out in order
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        rd_status("status_3");
        rd_data("data_11");
        rd_data("data_22");
        rd_data("data_33");
        rd_status("status_empty");

        // Fill until stalled, then one pop reopens rtr for the 17th word
        for (int i = 0; i < DEPTH + 1; i++) push_word(32'h100 + 32'(i));
        chk("full_rtr", {31'h0, rtr_o}, 32'h0);
        rd_status("status_full");
        rd_data("pop_full");
        chk("rtr_after_pop", {31'h0, rtr_o}, 32'h1);
        push_word(32'h110);
        rd_status("status_refull");

        // Underflow and flag clear
        wr_ctrl("flush_all", 32'h1);
        rd_data("underflow_read");
        rd_status("status_flags");
        wr_ctrl("clr_flags", 32'h2);
        rd_status("status_cleared");

        // Threshold irq timing
        for (int i = 0; i < THR - 1; i++) push_word(32'h200 + 32'(i));
        push_word(32'h2FF);
        chk("irq_same_cycle", {31'h0, irq}, 32'h0);
        idle(1);
        chk("irq_rise", {31'h0, irq}, 32'h1);
        rd_data("pop_irq");
        chk("irq_at_pop_ack", {31'h0, irq_at_ack}, 32'h1);
        chk("irq_fall", {31'h0, irq}, 32'h0);

        // Push on the same edge as a flush: flush wins
        @(negedge wb_clk_i);
        chk("rtr_before_flush", {31'h0, rtr_o}, 32'h1);
        rts_i     = 1'b1;
        data_i    = 32'hAA;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = BASE + 32'h8;
        wbs_dat_i = 32'h1;
        @(posedge wb_clk_i);
        #1;
        rts_i     = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        mq.delete();
        chk("flush_push_ack", {31'h0, wbs_ack_o}, 32'h1);
        rd_status("status_flush_push");

        // Reserved register and out-of-window address
        sb_q.push_back(32'h0);
        bus("reserved_rd", BASE + 32'hC, 1'b0, 32'h0, 1'b1);
        bus("out_of_range", BASE + 32'h10, 1'b0, 32'h0, 1'b0);

        // Reset with a read in flight and five words queued
        for (int i = 0; i < 5; i++) push_word(32'h300 + 32'(i));
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = BASE;
        wb_rst_i  = 1'b1;
        @(posedge wb_clk_i);
        #1;
        chk("midrst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("midrst_dat", wbs_dat_o, 32'h0);
        chk("midrst_rtr", {31'h0, rtr_o}, 32'h1);
        @(negedge wb_clk_i);
        wb_rst_i  = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        mq.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        rd_status("status_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
